run_sequencer: RTL and testbench
================================

# run_sequencer

Upstream controller for the `fsm_test` stage. It accepts a start command carrying a run count and issues that many single-cycle `o_run` pulses to the downstream FSM, one at a time. After each pulse it waits for the FSM's `o_done` pulse before issuing the next, and it aborts with a timeout flag if a done never arrives. It replaces hand-written testbench stimulus as the source of the FSM's `i_run` in the integrated design.

## Interface

Parameters:
- `CNT_WIDTH`, default 8: width of the run count and completed-run counter.
- `TIMEOUT`, default 16: maximum cycles spent waiting for one done pulse. Must be ≥ 2.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `i_start` input 1: start command, sampled only in IDLE.
- `i_num_run` input CNT_WIDTH: number of runs, latched with an accepted `i_start`.
- `i_done` input 1: done pulse from the downstream FSM (its `o_done`).
- `o_run` output 1: one-cycle run pulse to the downstream FSM (its `i_run`).
- `o_busy` output 1: high whenever state ≠ IDLE.
- `o_run_cnt` output CNT_WIDTH: runs completed in the current/last sequence.
- `o_all_done` output 1: one-cycle pulse when the sequence completes normally.
- `o_timeout` output 1: sticky error flag; cleared by reset or by the next accepted start.

## Operation

- States: IDLE, LAUNCH, WAIT, DONE, ERR. All outputs are registered or decoded directly from state; no combinational input-to-output paths.
- Reset (sync, high): state=IDLE. `o_run`=0, `o_busy`=0, `o_run_cnt`=0, `o_all_done`=0, `o_timeout`=0. Latched count and wait counter are 0.
- IDLE:
  - `i_start`=1 latches `i_num_run`, clears `o_run_cnt` and `o_timeout`.
  - Goes to LAUNCH if the count is ≠ 0, else to DONE.
  - `i_done` is ignored.
- LAUNCH:
  - `o_run`=1 for exactly this cycle.
  - Clears the wait counter; next state WAIT unconditionally.
  - `i_done` is ignored here.
- WAIT: the wait counter increments every cycle.
  - `i_done`=1: `o_run_cnt`+1. Go to LAUNCH if `o_run_cnt`+1 < latched count, else to DONE.
  - No `i_done` and wait counter == TIMEOUT-1: go to ERR.
  - `i_done` in the same cycle as the timeout condition: done wins and no timeout is raised.
- DONE: `o_all_done`=1 for this one cycle; next state IDLE.
- ERR: sets `o_timeout`=1 (sticky); next state IDLE. `o_all_done` is not asserted. `o_run_cnt` holds the runs completed before the abort.
- `i_start` outside IDLE is ignored entirely; `i_num_run` changes outside IDLE have no effect.
- Arithmetic:
  - `o_run_cnt` is CNT_WIDTH bits and cannot wrap, because it stops at the latched count.
  - Maximum sequence length is 2^CNT_WIDTH−1.
  - The wait counter is $clog2(TIMEOUT) bits.
- Reset mid-sequence returns to IDLE on the next edge with all reset values. No further `o_run` is issued.

## Timing

- `i_start` sampled at edge E (end of cycle t) → `o_run`=1 and `o_busy`=1 in cycle t+1.
- `i_done` sampled in cycle w, more runs pending → `o_run_cnt` updated and `o_run`=1 in cycle w+1. Minimum spacing between `o_run` pulses is 2 cycles (LAUNCH, WAIT with immediate done).
- `i_done` in cycle w, last run → `o_run_cnt`=N and `o_all_done`=1 in cycle w+1; `o_busy`=0 in cycle w+2; a new `i_start` is accepted in cycle w+2.
- Zero-count start in cycle t → `o_all_done`=1 in cycle t+1 and `o_busy` low in cycle t+2. No `o_run` is issued.
- Timeout: the first WAIT cycle is w0. If no done arrives in w0..w0+TIMEOUT-1, ERR occurs in cycle w0+TIMEOUT and `o_timeout`=1 from cycle w0+TIMEOUT+1.
- Throughput per run = 1 (LAUNCH) + done latency of the FSM (≥1 WAIT cycle).

## Test plan

- Reset: assert `reset` for 2 cycles with random inputs → all outputs 0, `o_busy`=0; an `i_start` held during reset produces no `o_run`.
- Nominal: `i_num_run`=3, FSM model returns `i_done` 4 cycles after each `o_run` → exactly 3 `o_run` pulses 5 cycles apart, `o_run_cnt` steps 1,2,3, one `o_all_done` pulse, `o_timeout`=0.
- Zero count: `i_start` with `i_num_run`=0 → no `o_run`, `o_all_done` pulse in the next cycle, `o_run_cnt`=0.
- Timeout: `i_num_run`=2, `TIMEOUT`=16, first done at 2 cycles, second never arrives → `o_run_cnt`=1, `o_timeout`=1 exactly 16 WAIT cycles after the second `o_run`, no `o_all_done`. Next `i_start` clears `o_timeout`.
- Boundary: `i_done` on the 16th WAIT cycle (counter == TIMEOUT-1) → counted as done, no timeout; `i_done` during LAUNCH or IDLE → ignored, count unchanged.
- Interference: `i_start` with a different `i_num_run` pulsed mid-sequence → ignored, original count completes. `reset` asserted during WAIT → IDLE next cycle, no further `o_run`.

Source files
------------

// File: rtl/run_sequencer.sv
// Purpose : issues i_num_run single-cycle o_run pulses, waiting for i_done after each, with timeout abort.
// Latency : o_run one cycle after an accepted i_start; next o_run one cycle after i_done.
// Backpr. : none; a missing i_done for TIMEOUT wait cycles aborts the sequence and sets o_timeout.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   i_start, i_num_run   : start command and run count (sampled only while idle)
//   i_done               : done pulse returned by the downstream FSM
//   o_run                : one-cycle run pulse to the downstream FSM
//   o_busy               : high whenever a sequence is in progress
//   o_run_cnt            : runs completed in the current/last sequence
//   o_all_done           : one-cycle pulse on normal completion
//   o_timeout            : sticky abort flag, cleared by reset or the next accepted start
module run_sequencer #(
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_num_run,
    input  logic                 i_done,
    output logic                 o_run,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_run_cnt,
    output logic                 o_all_done,
    output logic                 o_timeout
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_num_run;
    logic [CNT_WIDTH-1:0] r_run_cnt;
    logic [WW-1:0]        r_wait;
    logic                 r_timeout;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_more;

    // r_run_cnt < r_num_run whenever we are waiting, so the increment cannot wrap.
    assign w_cnt_inc = r_run_cnt + CNT_WIDTH'(1);
    assign w_more    = (w_cnt_inc < r_num_run);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_run != '0) ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last allowed wait cycle still counts.
                if (i_done) begin
                    w_next = w_more ? S_LAUNCH : S_DONE;
                end else if (r_wait == LAST_WAIT) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_run <= '0;
            r_run_cnt <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_run <= i_num_run;
                        r_run_cnt <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_wait <= '0;
                end
                S_WAIT: begin
                    r_wait <= r_wait + WW'(1);
                    if (i_done) begin
                        r_run_cnt <= w_cnt_inc;
                    end
                end
                S_ERR: begin
                    r_timeout <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are pure state decodes or registers: no input-to-output paths.
    assign o_run      = (r_state == S_LAUNCH);
    assign o_busy     = (r_state != S_IDLE);
    assign o_all_done = (r_state == S_DONE);
    assign o_run_cnt  = r_run_cnt;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_run_sequencer.sv
// Purpose : self-checking bench for run_sequencer with an FSM done-return model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_run_sequencer;

    localparam int CW = 8;
    localparam int TO = 16;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic [CW-1:0] i_num_run;
    logic          i_done;
    logic          o_run;
    logic          o_busy;
    logic [CW-1:0] o_run_cnt;
    logic          o_all_done;
    logic          o_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    run_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_num_run  (i_num_run),
        .i_done     (i_done),
        .o_run      (o_run),
        .o_busy     (o_busy),
        .o_run_cnt  (o_run_cnt),
        .o_all_done (o_all_done),
        .o_timeout  (o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // num: run count; dly: cycles from o_run to i_done; miss: run index that never gets
    // a done (-1 none); ld: also pulse i_done in each LAUNCH cycle; intf: pulse a second
    // start mid-sequence with a different count.
    typedef struct {
        int num;
        int dly;
        int miss;
        int ld;
        int intf;
        int exp_runs;
        int exp_cnt;
        int exp_ad;
        int exp_to;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts a sequence at the current negedge, plays the downstream FSM, and returns
    // at the negedge where o_busy is observed low again.
    task automatic run_vec(input int idx);
        vec_t v;
        int c, runs, last_run, due, ad_n, ad_cyc, to_cyc, gap_err, step_err, lat1;
        bit fin;
        v = tbl[idx];
        c = 0; runs = 0; last_run = -1; due = -1; ad_n = 0; ad_cyc = -1; to_cyc = -1;
        gap_err = 0; step_err = 0; lat1 = -1; fin = 1'b0;
        i_start   = 1'b1;
        i_num_run = CW'(v.num);
        i_done    = 1'b0;
        while (!fin && c < 700) begin
            @(negedge clk);
            c++;
            i_start   = 1'b0;
            i_num_run = CW'(v.num);
            if (c == 1) begin
                check($sformatf("v%0d_first_busy", idx), int'(o_busy), 1);
                check($sformatf("v%0d_first_timeout", idx), int'(o_timeout), 0);
                check($sformatf("v%0d_first_run", idx), int'(o_run), (v.num != 0) ? 1 : 0);
            end
            if (o_run) begin
                if (runs == 0) lat1 = c;
                else if (c - last_run != v.dly + 1) gap_err++;
                if (int'(o_run_cnt) != runs) step_err++;
                due = (runs != v.miss) ? c + v.dly : -1;
                runs++;
                last_run = c;
            end
            if (o_all_done) begin
                ad_n++;
                ad_cyc = c;
            end
            if (o_timeout && to_cyc < 0) to_cyc = c;
            i_done = (c == due) || (v.ld != 0 && o_run);
            if (v.intf != 0 && c == 3) begin
                i_start   = 1'b1;
                i_num_run = CW'(v.num + 5);
            end
            if (c > 1 && !o_busy) fin = 1'b1;
        end
        i_done  = 1'b0;
        i_start = 1'b0;
        check($sformatf("v%0d_finished", idx), int'(fin), 1);
        check($sformatf("v%0d_runs", idx), runs, v.exp_runs);
        check($sformatf("v%0d_run_cnt", idx), int'(o_run_cnt), v.exp_cnt);
        check($sformatf("v%0d_all_done_pulses", idx), ad_n, v.exp_ad);
        check($sformatf("v%0d_timeout", idx), int'(o_timeout), v.exp_to);
        check($sformatf("v%0d_cnt_steps", idx), step_err, 0);
        if (runs > 0) check($sformatf("v%0d_start_to_run", idx), lat1, 1);
        if (runs > 1) check($sformatf("v%0d_run_spacing", idx), gap_err, 0);
        if (v.exp_ad != 0) begin
            if (v.num > 0) check($sformatf("v%0d_done_to_all_done", idx), ad_cyc - last_run, v.dly + 1);
            else           check($sformatf("v%0d_zero_all_done", idx), ad_cyc, 1);
            check($sformatf("v%0d_idle_after_all_done", idx), c, ad_cyc + 1);
        end
        if (v.exp_to != 0) begin
            check($sformatf("v%0d_timeout_cycle", idx), to_cyc - last_run, TO + 2);
            check($sformatf("v%0d_idle_at_timeout", idx), c, to_cyc);
        end
    endtask

    initial begin
        int k;
        //           num dly miss ld intf runs cnt ad to
        tbl[0] = '{  3,  4, -1, 0, 0,   3,  3, 1, 0};   // nominal, 5-cycle spacing
        tbl[1] = '{  0,  1, -1, 0, 0,   0,  0, 1, 0};   // zero count
        tbl[2] = '{  2,  2,  1, 0, 0,   2,  1, 0, 1};   // second done never arrives
        tbl[3] = '{  1,  1, -1, 0, 0,   1,  1, 1, 0};   // start clears sticky timeout
        tbl[4] = '{  2, 16, -1, 0, 0,   2,  2, 1, 0};   // done on last wait cycle
        tbl[5] = '{  1, 17, -1, 0, 0,   1,  0, 0, 1};   // done one cycle too late
        tbl[6] = '{  1,  1,  0, 1, 0,   1,  0, 0, 1};   // done only in LAUNCH: ignored
        tbl[7] = '{  4,  3, -1, 0, 1,   4,  4, 1, 0};   // mid-sequence start ignored
        tbl[8] = '{255,  1, -1, 0, 0, 255, 255, 1, 0};  // maximum length, min spacing

        // Reset with random inputs, start held high.
        reset     = 1'b1;
        i_start   = 1'b1;
        i_num_run = CW'($urandom);
        i_done    = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_%0d", i),
                  int'({o_run, o_busy, o_all_done, o_timeout, o_run_cnt}), 0);
            i_num_run = CW'($urandom);
            i_done    = 1'($urandom);
        end
        reset   = 1'b0;
        i_start = 1'b0;
        i_done  = 1'b0;
        @(negedge clk);
        check("post_reset_run", int'(o_run), 0);
        check("post_reset_busy", int'(o_busy), 0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // i_done while idle must not touch the count.
        for (int i = 0; i < 3; i++) begin
            i_done = 1'b1;
            @(negedge clk);
        end
        i_done = 1'b0;
        @(negedge clk);
        check("idle_done_cnt", int'(o_run_cnt), 255);
        check("idle_done_busy", int'(o_busy), 0);

        // Reset during WAIT: back to idle, no further run pulses.
        i_start   = 1'b1;
        i_num_run = CW'(3);
        @(negedge clk);
        i_start = 1'b0;
        k = 0;
        while (!o_run && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("midreset_saw_run", int'(o_run), 1);
        repeat (2) @(negedge clk);
        check("midreset_in_wait", int'(o_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_outputs",
              int'({o_run, o_busy, o_all_done, o_timeout, o_run_cnt}), 0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_run || o_busy) k++;
        end
        check("midreset_no_activity", k, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
